pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline stall controller for the 5-stage core. Merges stall requests from ID (load-use),
//  EX (multi-cycle ops) and MEM (IN/OUT port transfers) into the stall[5:0] vector consumed by
//  pc_reg, if_id, id_ex, ex_mem and mem_wb. Owns the IN/OUT handshake FSM with the I/O port,
//  including a timeout, and keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  IO_TIMEOUT  255  max cycles in REQ waiting for io_ack before forced release with io_err
//  CNT_W       32   width of stall_cycles performance counter
// PORTS
//  clk           in   1      core clock; all state updates on posedge
//  rst           in   1      synchronous, active-low reset
//  stallreq_id   in   1      ID stage requests 1-cycle stall (load-use), level
//  stallreq_ex   in   1      EX stage multi-cycle op busy, level, held until done
//  mem_io_start  in   1      MEM stage holds an IN/OUT instruction (level while present)
//  mem_io_dir    in   1      1 = OUT, 0 = IN; valid with mem_io_start
//  io_ack        in   1      I/O port completes transfer (1-cycle pulse)
//  io_req        out  1      request to I/O port, held in REQ
//  io_dir        out  1      registered copy of mem_io_dir captured on REQ entry
//  io_err        out  1      1-cycle pulse: transfer ended by timeout
//  io_busy       out  1      FSM not in IDLE
//  stall         out  6      [0]pc [1]if [2]id [3]ex [4]mem [5]wb; `Stop=1, `NoStop=0
//  stall_cycles  out  CNT_W  cycles with stall[0]==`Stop, saturating
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, wait_cnt=0, io_req=0, io_dir=0, io_err=0, stall_cycles=0.
//   stall is combinational; during reset it is forced to 6'b000000. Reset mid-REQ aborts silently.
//  stall encoding (combinational, highest requesting stage wins):
//   mem_stall = (state==IDLE & mem_io_start) | state==REQ  -> stall=6'b011111
//   else stallreq_ex                                        -> stall=6'b001111
//   else stallreq_id                                        -> stall=6'b000111
//   else                                                    -> stall=6'b000000
//   Invariant: stall[k]==1 implies stall[j]==1 for all j<k; stall[5] always 0.
//   Bubble semantics: stage register k+1 loads NOP when stall[k]=1 & stall[k+1]=0.
//  FSM (IDLE, REQ, DONE), registered:
//   IDLE: mem_io_start=1 -> REQ; capture io_dir<=mem_io_dir, wait_cnt<=0. io_ack ignored.
//   REQ : io_req=1. io_ack=1 -> DONE (io_err stays 0). else wait_cnt==IO_TIMEOUT-1 -> DONE,
//         io_err<=1. else wait_cnt<=wait_cnt+1. ack and timeout same cycle: ack wins, no err.
//   DONE: 1 cycle; no IO stall, io_req=0, io_err cleared next cycle; MEM instruction advances.
//         mem_io_start ignored in DONE (same instruction still visible) -> IDLE unconditionally.
//  Latency: REQ entry 1 cycle after mem_io_start seen; pipeline released the cycle after io_ack.
//   Min IO stall = 2 cycles (IDLE-detect + REQ w/ immediate ack).
//  Back-to-back IN/OUT: second instruction reaches MEM in cycle after DONE, seen in IDLE, new REQ.
//  wait_cnt width = $clog2(IO_TIMEOUT+1); io_ack outside REQ is dropped.
//  stall_cycles: +1 each cycle stall[0]==1 and rst==1; holds at 2^CNT_W-1.
// STRUCTURE
//  defines.v gets: `Stop/`NoStop (exist), `IoIdle/`IoReq/`IoDone 2-bit state codes,
//   `StallNone/`StallId/`StallEx/`StallMem 6-bit vectors.
//  Sub-module: sat_counter #(W) (clk, rst, inc, q) for stall_cycles; FSM and stall mux inline.
// TESTING
//  1 stallreq_id=1 one cycle, others 0 -> stall=6'b000111 that cycle, 0 next; stall_cycles=1.
//  2 stallreq_ex=1 for 4 cycles plus stallreq_id=1 -> stall=6'b001111 all 4 cycles; count=4.
//  3 mem_io_start=1, dir=1, io_ack 3 cycles after REQ entry -> io_req high 4 cycles, io_dir=1,
//    stall=6'b011111 for 5 cycles, DONE 1 cycle with stall=0, io_err never set.
//  4 IO_TIMEOUT=4, no ack -> REQ 4 cycles, io_err pulse 1 cycle in DONE, then IDLE.
//  5 ack on exact timeout cycle -> io_err=0; stallreq_ex asserted during REQ -> stall stays 011111.
//  6 rst=0 in 2nd REQ cycle -> next cycle io_req=0, io_busy=0, stall_cycles=0; CNT_W=4 saturates at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller.
//   - Stop/NoStop levels for the per-stage stall bits
//   - IN/OUT handshake FSM state codes
//   - The four legal stall vectors, one per requesting stage
//   - stall_vec(): priority merge of the stage requests (highest stage wins)
package pipe_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        IO_IDLE = 2'b00,
        IO_REQ  = 2'b01,
        IO_DONE = 2'b10
    } io_state_e;

    // bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    function automatic logic [5:0] stall_vec(input logic mem_stall,
                                             input logic ex_stall,
                                             input logic id_stall);
        if (mem_stall)     return STALL_MEM;
        else if (ex_stall) return STALL_EX;
        else if (id_stall) return STALL_ID;
        else               return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the stall-cycle performance count.
// Ports:
//   clk  in  1  clock, updates on posedge
//   rst  in  1  synchronous active-low reset, clears q
//   inc  in  1  count enable for this cycle
//   q    out W  current count, holds at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller for the 5-stage core.
// Merges ID/EX/MEM stall requests into the stall vector, runs the IN/OUT
// handshake with the I/O port (with timeout) and counts stalled cycles.
// Ports:
//   clk           in   1      core clock
//   rst           in   1      synchronous active-low reset
//   stallreq_id   in   1      load-use stall request
//   stallreq_ex   in   1      multi-cycle EX busy
//   mem_io_start  in   1      IN/OUT instruction present in MEM
//   mem_io_dir    in   1      1 = OUT, 0 = IN
//   io_ack        in   1      transfer complete pulse from I/O port
//   io_req        out  1      request to I/O port
//   io_dir        out  1      direction captured on REQ entry
//   io_err        out  1      pulse in DONE when the transfer timed out
//   io_busy       out  1      FSM not idle
//   stall         out  6      per-stage stall, [0]pc .. [5]wb
//   stall_cycles  out  CNT_W  saturating count of cycles with stall[0] set
//
// state   | meaning
// IO_IDLE | no transfer; an IN/OUT seen here stalls and launches REQ
// IO_REQ  | io_req held, waiting for io_ack or timeout
// IO_DONE | one release cycle; the finished IN/OUT leaves MEM
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int IO_TIMEOUT = 255,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             mem_io_start,
    input  logic             mem_io_dir,
    input  logic             io_ack,
    output logic             io_req,
    output logic             io_dir,
    output logic             io_err,
    output logic             io_busy,
    output logic [5:0]       stall,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(IO_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IO_TIMEOUT - 1);

    io_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              io_dir_q, io_dir_d;
    logic              io_err_q, io_err_d;
    logic              mem_stall;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        io_dir_d   = io_dir_q;
        io_err_d   = 1'b0;
        case (state_q)
            IO_IDLE: begin
                if (mem_io_start) begin
                    state_d    = IO_REQ;
                    io_dir_d   = mem_io_dir;
                    wait_cnt_d = '0;
                end
            end
            IO_REQ: begin
                // ack takes priority over a timeout landing in the same cycle
                if (io_ack) begin
                    state_d = IO_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d  = IO_DONE;
                    io_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            IO_DONE: begin
                // the completed IN/OUT is still in MEM this cycle; do not relaunch
                state_d = IO_IDLE;
            end
            default: begin
                state_d = IO_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IO_IDLE;
            wait_cnt_q <= '0;
            io_dir_q   <= 1'b0;
            io_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            io_dir_q   <= io_dir_d;
            io_err_q   <= io_err_d;
        end
    end

    // stall in the detect cycle too, so the IN/OUT cannot leave MEM before REQ
    assign mem_stall = ((state_q == IO_IDLE) && mem_io_start) || (state_q == IO_REQ);

    assign stall   = rst ? stall_vec(mem_stall, stallreq_ex, stallreq_id) : STALL_NONE;
    assign io_req  = (state_q == IO_REQ);
    assign io_dir  = io_dir_q;
    assign io_err  = io_err_q;
    assign io_busy = (state_q != IO_IDLE);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (rst && (stall[0] == STOP)),
        .q   (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       stallreq_id, stallreq_ex, mem_io_start, mem_io_dir, io_ack;
    logic       io_req, io_dir, io_err, io_busy;
    logic [5:0] stall;
    logic [3:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .IO_TIMEOUT (4),
        .CNT_W      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .mem_io_start (mem_io_start),
        .mem_io_dir   (mem_io_dir),
        .io_ack       (io_ack),
        .io_req       (io_req),
        .io_dir       (io_dir),
        .io_err       (io_err),
        .io_busy      (io_busy),
        .stall        (stall),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to the next cycle: inputs change just after posedge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        mem_io_start = 1'b0;
        mem_io_dir   = 1'b0;
        io_ack       = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        // reset state; stall forced low even with a request present
        stallreq_ex = 1'b1;
        sample();
        chk("rst_stall", 32'(stall), 32'h00);
        chk("rst_req", 32'(io_req), 0);
        chk("rst_busy", 32'(io_busy), 0);
        chk("rst_err", 32'(io_err), 0);
        chk("rst_dir", 32'(io_dir), 0);
        chk("rst_cnt", 32'(stall_cycles), 0);

        // 1: single load-use stall
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        stallreq_id = 1'b1;
        sample();
        chk("t1_stall", 32'(stall), 32'h07);
        chk("t1_cnt0", 32'(stall_cycles), 0);
        next_cycle();
        stallreq_id = 1'b0;
        sample();
        chk("t1_stall_off", 32'(stall), 32'h00);
        chk("t1_cnt1", 32'(stall_cycles), 1);

        // 2: EX busy 4 cycles outranks ID
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            stallreq_ex = 1'b1;
            stallreq_id = 1'b1;
            sample();
            chk($sformatf("t2_stall%0d", i), 32'(stall), 32'h0F);
            chk($sformatf("t2_cnt%0d", i), 32'(stall_cycles), 32'(i));
        end
        next_cycle();
        clear_inputs();
        sample();
        chk("t2_stall_off", 32'(stall), 32'h00);
        chk("t2_cnt", 32'(stall_cycles), 4);

        // 3: OUT with ack in 4th REQ cycle (also the timeout cycle: ack wins)
        do_reset();
        mem_io_start = 1'b1;
        mem_io_dir   = 1'b1;
        sample();
        chk("t3_detect_stall", 32'(stall), 32'h1F);
        chk("t3_detect_req", 32'(io_req), 0);
        chk("t3_detect_busy", 32'(io_busy), 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            mem_io_dir = 1'b0;
            io_ack = (i == 3);
            sample();
            chk($sformatf("t3_req%0d", i), 32'(io_req), 1);
            chk($sformatf("t3_stall%0d", i), 32'(stall), 32'h1F);
            chk($sformatf("t3_dir%0d", i), 32'(io_dir), 1);
            chk($sformatf("t3_err%0d", i), 32'(io_err), 0);
        end
        next_cycle();
        io_ack = 1'b0;
        sample();
        chk("t3_done_stall", 32'(stall), 32'h00);
        chk("t3_done_req", 32'(io_req), 0);
        chk("t3_done_busy", 32'(io_busy), 1);
        chk("t3_done_err", 32'(io_err), 0);
        chk("t3_cnt", 32'(stall_cycles), 5);
        next_cycle();
        mem_io_start = 1'b0;
        sample();
        chk("t3_idle_busy", 32'(io_busy), 0);
        chk("t3_idle_err", 32'(io_err), 0);
        chk("t3_idle_cnt", 32'(stall_cycles), 5);

        // 4: IN with no ack -> timeout after 4 REQ cycles
        do_reset();
        mem_io_start = 1'b1;
        mem_io_dir   = 1'b0;
        sample();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            sample();
            chk($sformatf("t4_req%0d", i), 32'(io_req), 1);
            chk($sformatf("t4_err%0d", i), 32'(io_err), 0);
        end
        next_cycle();
        sample();
        chk("t4_done_err", 32'(io_err), 1);
        chk("t4_done_req", 32'(io_req), 0);
        chk("t4_done_stall", 32'(stall), 32'h00);
        chk("t4_dir", 32'(io_dir), 0);
        next_cycle();
        mem_io_start = 1'b0;
        sample();
        chk("t4_idle_err", 32'(io_err), 0);
        chk("t4_idle_busy", 32'(io_busy), 0);
        chk("t4_cnt", 32'(stall_cycles), 5);

        // 5a: stray ack in IDLE dropped; immediate ack = 2-cycle stall; EX under IO
        do_reset();
        mem_io_start = 1'b1;
        io_ack       = 1'b1;
        sample();
        chk("t5_detect_stall", 32'(stall), 32'h1F);
        next_cycle();
        stallreq_ex = 1'b1;
        sample();
        chk("t5_req_after_stray_ack", 32'(io_req), 1);
        chk("t5_req_stall", 32'(stall), 32'h1F);
        next_cycle();
        io_ack = 1'b0;
        sample();
        chk("t5_done_ex_stall", 32'(stall), 32'h0F);
        chk("t5_done_err", 32'(io_err), 0);
        // 5b: back-to-back IN/OUT, ack exactly on the timeout cycle
        next_cycle();
        stallreq_ex = 1'b0;
        sample();
        chk("t5_b2b_stall", 32'(stall), 32'h1F);
        chk("t5_b2b_busy", 32'(io_busy), 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            stallreq_ex = 1'b1;
            io_ack = (i == 3);
            sample();
            chk($sformatf("t5_b2b_stall%0d", i), 32'(stall), 32'h1F);
        end
        next_cycle();
        io_ack = 1'b0;
        stallreq_ex = 1'b0;
        sample();
        chk("t5_tie_err", 32'(io_err), 0);
        chk("t5_tie_busy", 32'(io_busy), 1);
        chk("t5_cnt", 32'(stall_cycles), 8);

        // 6: reset in 2nd REQ cycle aborts; then saturate the 4-bit counter
        do_reset();
        mem_io_start = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        sample();
        chk("t6_rst_stall", 32'(stall), 32'h00);
        next_cycle();
        clear_inputs();
        sample();
        chk("t6_abort_req", 32'(io_req), 0);
        chk("t6_abort_busy", 32'(io_busy), 0);
        chk("t6_abort_cnt", 32'(stall_cycles), 0);
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) next_cycle();
            stallreq_ex = 1'b1;
            sample();
            if (i == 14) chk("t6_cnt14", 32'(stall_cycles), 14);
            if (i == 15) chk("t6_cnt15", 32'(stall_cycles), 15);
        end
        chk("t6_sat", 32'(stall_cycles), 15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
